// File: rtl/goldschmidt_sched.sv
// Round-robin front end and stage sequencer for the shared Goldschmidt divider datapath.
// Latency: a request handshake in cycle t gives resp_valid in cycle t+3+2*ITER.
// Backpressure: DONE holds until resp_ready; no request is accepted until the response retires.
module goldschmidt_sched #(
    parameter int WIDTH = 30,
    parameter int ITER  = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_num,
    input  logic [WIDTH-1:0] req0_den,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_num,
    input  logic [WIDTH-1:0] req1_den,
    output logic             div_mode,
    output logic             div_stage,
    output logic [WIDTH-1:0] div_num,
    output logic [WIDTH-1:0] div_den,
    input  logic [WIDTH-1:0] div_quotient,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic             resp_id,
    output logic [WIDTH-1:0] resp_quotient,
    output logic             busy
);

    localparam int CNT_W = $clog2(2*ITER+2);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(2*ITER+1);
    localparam logic [CNT_W-1:0] CNT_K    = CNT_W'(2);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic             last_grant;
    logic             grant0, grant1;
    logic             accept;

    // Requester 0 wins unless requester 1 is also pending and 0 was served last.
    assign grant0 = req0_valid & (~req1_valid | last_grant);
    assign grant1 = req1_valid & ~grant0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        div_mode   = 1'b0;
        div_stage  = 1'b1;
        resp_valid = 1'b0;
        busy       = 1'b1;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                busy       = 1'b0;
                req0_ready = grant0;
                req1_ready = grant1;
                accept     = grant0 | grant1;
                if (accept) state_nxt = RUN;
            end
            RUN: begin
                div_mode  = (cnt >= CNT_K);
                div_stage = cnt[0];
                if (cnt == CNT_LAST) state_nxt = DONE;
            end
            DONE: begin
                resp_valid = 1'b1;
                if (resp_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt           <= '0;
            last_grant    <= 1'b1;
            div_num       <= '0;
            div_den       <= '0;
            resp_quotient <= '0;
            resp_id       <= 1'b0;
        end else if (accept) begin
            div_num    <= grant1 ? req1_num : req0_num;
            div_den    <= grant1 ? req1_den : req0_den;
            resp_id    <= grant1;
            last_grant <= grant1;
            cnt        <= '0;
        end else if (state == RUN) begin
            cnt <= cnt + 1'b1;
            // The n register last moved on the previous stage-0 cycle, so it is final here.
            if (cnt == CNT_LAST) resp_quotient <= div_quotient;
        end
    end

endmodule

// File: tb/tb_goldschmidt_sched.sv
// Scoreboard bench for goldschmidt_sched with a stub quotient or a behavioural Q1.29 divider.
module tb_goldschmidt_sched;

    localparam int WIDTH = 30;
    localparam int ITER  = 5;
    localparam logic [WIDTH-1:0] STUB_Q = 30'h0ABC_DEF0;
    localparam logic [WIDTH-1:0] K0     = 30'h3000_0000;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             req0_valid = 1'b0, req1_valid = 1'b0;
    logic             req0_ready, req1_ready;
    logic [WIDTH-1:0] req0_num = '0, req0_den = '0, req1_num = '0, req1_den = '0;
    logic             div_mode, div_stage;
    logic [WIDTH-1:0] div_num, div_den, div_quotient;
    logic             resp_valid, resp_ready = 1'b0, resp_id;
    logic [WIDTH-1:0] resp_quotient;
    logic             busy;
    logic             use_real = 1'b0;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic             id;
        logic [WIDTH-1:0] q;
        longint           tol;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    goldschmidt_sched #(.WIDTH(WIDTH), .ITER(ITER)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_num(req0_num), .req0_den(req0_den),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_num(req1_num), .req1_den(req1_den),
        .div_mode(div_mode), .div_stage(div_stage), .div_num(div_num), .div_den(div_den),
        .div_quotient(div_quotient),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
        .resp_quotient(resp_quotient), .busy(busy)
    );

    // Behavioural divider: Q1.29 products, k = 2 - d.
    function automatic logic [WIDTH-1:0] mulq(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        logic [2*WIDTH-1:0] p;
        p = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
        return p[2*WIDTH-2:WIDTH-1];
    endfunction

    function automatic logic [WIDTH-1:0] two_minus(input logic [WIDTH-1:0] d);
        logic [WIDTH:0] t;
        t = {1'b1, {WIDTH{1'b0}}} - {1'b0, d};
        return t[WIDTH-1:0];
    endfunction

    logic [WIDTH-1:0] m_n, m_d, m_k;
    always @(posedge clk) begin
        if (!div_stage) begin
            m_n <= div_mode ? mulq(m_n, m_k) : mulq(div_num, K0);
        end else begin
            m_d <= div_mode ? mulq(m_d, m_k) : mulq(div_den, K0);
            m_k <= two_minus(div_mode ? mulq(m_d, m_k) : mulq(div_den, K0));
        end
    end
    assign div_quotient = use_real ? m_n : STUB_Q;

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic wait_valid(output int cyc);
        logic saw_ready;
        saw_ready = 1'b0;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
            if (req0_ready || req1_ready) saw_ready = 1'b1;
        end while (!resp_valid && cyc < 60);
        checks++;
        if (resp_valid !== 1'b1) begin
            errors++;
            $display("FAIL resp_timeout: resp_valid=%b after %0d cycles, required 1", resp_valid, cyc);
        end
        checks++;
        if (saw_ready !== 1'b0) begin
            errors++;
            $display("FAIL ready_while_busy: a req ready seen during RUN/DONE, required none");
        end
    endtask

    task automatic take_resp();
        exp_t   e;
        longint diff;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL sb_empty: response id=%0d q=%h with nothing expected", resp_id, resp_quotient);
        end else begin
            e = sb.pop_front();
            checks++;
            if (resp_id !== e.id) begin
                errors++;
                $display("FAIL resp_id: got %0d, required %0d", resp_id, e.id);
            end
            diff = longint'(resp_quotient) - longint'(e.q);
            if (diff < 0) diff = -diff;
            checks++;
            if ($isunknown(resp_quotient) || diff > e.tol) begin
                errors++;
                $display("FAIL resp_quotient: got %h, required %h (tol %0d)", resp_quotient, e.q, e.tol);
            end
        end
        resp_ready = 1'b1;
        #1;
        checks++;
        if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
            errors++;
            $display("FAIL ready_in_resp_hs: ready0=%b ready1=%b, required 0 0", req0_ready, req1_ready);
        end
        @(posedge clk);
        #1 resp_ready = 1'b0;
    endtask

    task automatic test_reset();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        checks++;
        if ({resp_valid, busy, req0_ready, req1_ready, div_mode, div_stage, resp_id} !== 7'b0000010) begin
            errors++;
            $display("FAIL reset_ctrl: valid/busy/r0/r1/mode/stage/id=%b, required 0000010",
                     {resp_valid, busy, req0_ready, req1_ready, div_mode, div_stage, resp_id});
        end
        checks++;
        if (div_num !== '0 || div_den !== '0 || resp_quotient !== '0) begin
            errors++;
            $display("FAIL reset_data: num=%h den=%h q=%h, required 0", div_num, div_den, resp_quotient);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_single();
        int cyc;
        @(negedge clk);
        req0_valid = 1'b1;
        req0_num = 30'h1000_0000;
        req0_den = 30'h2000_0000;
        #1;
        checks++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            errors++;
            $display("FAIL single_ready: r0=%b r1=%b, required 1 0", req0_ready, req1_ready);
        end
        sb.push_back('{id: 1'b0, q: STUB_Q, tol: 0});
        @(posedge clk);
        #1 req0_valid = 1'b0;
        for (int i = 0; i < 2*ITER+2; i++) begin
            @(negedge clk);
            checks++;
            if ({div_mode, div_stage} !== {(i >= 2) ? 1'b1 : 1'b0, i[0]} || resp_valid !== 1'b0) begin
                errors++;
                $display("FAIL seq_%0d: mode/stage/valid=%b%b%b, required %b%b0",
                         i, div_mode, div_stage, resp_valid, (i >= 2) ? 1'b1 : 1'b0, i[0]);
            end
        end
        wait_valid(cyc);
        checks++;
        if (cyc != 1) begin
            errors++;
            $display("FAIL latency: resp_valid at cycle %0d, required %0d", 2*ITER+2+cyc, 3+2*ITER);
        end
        take_resp();
    endtask

    task automatic test_contention();
        int cyc;
        req0_valid = 1'b1; req0_num = 30'h0111_1111; req0_den = 30'h1222_2222;
        req1_valid = 1'b1; req1_num = 30'h0333_3333; req1_den = 30'h1444_4444;
        do_reset();
        for (int g = 0; g < 4; g++) begin
            if (g > 0) @(negedge clk);
            #1;
            checks++;
            if (req0_ready !== ((g % 2) == 0) || req1_ready !== ((g % 2) == 1)) begin
                errors++;
                $display("FAIL grant_%0d: r0=%b r1=%b, required %0d %0d",
                         g, req0_ready, req1_ready, (g % 2) == 0, (g % 2) == 1);
            end
            sb.push_back('{id: ((g % 2) == 1), q: STUB_Q, tol: 0});
            @(posedge clk);
            wait_valid(cyc);
            take_resp();
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    task automatic test_backpressure();
        int cyc;
        @(negedge clk);
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        #1;
        checks++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_grant: r0=%b r1=%b, required 1 0", req0_ready, req1_ready);
        end
        sb.push_back('{id: 1'b0, q: STUB_Q, tol: 0});
        @(posedge clk);
        wait_valid(cyc);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checks++;
            if ({resp_valid, busy, div_stage, req0_ready, req1_ready} !== 5'b11100 || resp_quotient !== STUB_Q) begin
                errors++;
                $display("FAIL stall_%0d: valid/busy/stage/r0/r1=%b q=%h, required 11100 q=%h",
                         i, {resp_valid, busy, div_stage, req0_ready, req1_ready}, resp_quotient, STUB_Q);
            end
        end
        take_resp();
        @(negedge clk);
        #1;
        checks++;
        if (req0_ready !== 1'b0 || req1_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_next_grant: r0=%b r1=%b, required 0 1", req0_ready, req1_ready);
        end
        sb.push_back('{id: 1'b1, q: STUB_Q, tol: 0});
        @(posedge clk);
        #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        wait_valid(cyc);
        take_resp();
    endtask

    task automatic test_operand_stability();
        int cyc;
        @(negedge clk);
        req0_valid = 1'b1;
        req0_num = 30'h0123_4567;
        req0_den = 30'h1765_4321;
        sb.push_back('{id: 1'b0, q: STUB_Q, tol: 0});
        @(posedge clk);
        #1;
        req0_valid = 1'b0;
        req0_num = 30'h3FFF_FFFF;
        req0_den = 30'h2AAA_AAAA;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
            checks++;
            if (div_num !== 30'h0123_4567 || div_den !== 30'h1765_4321) begin
                errors++;
                $display("FAIL operands_%0d: num=%h den=%h, required 01234567 17654321", cyc, div_num, div_den);
            end
        end while (!resp_valid && cyc < 60);
        checks++;
        if (resp_valid !== 1'b1) begin
            errors++;
            $display("FAIL stab_timeout: resp_valid=%b, required 1", resp_valid);
        end
        take_resp();
    endtask

    task automatic test_reset_mid_run();
        int  cyc;
        logic seen;
        @(negedge clk);
        req0_valid = 1'b1;
        req0_num = 30'h0555_0000;
        req0_den = 30'h1AAA_0000;
        sb.push_back('{id: 1'b0, q: STUB_Q, tol: 0});
        @(posedge clk);
        #1 req0_valid = 1'b0;
        repeat (7) @(negedge clk);
        checks++;
        if (busy !== 1'b1 || div_mode !== 1'b1 || div_stage !== 1'b0) begin
            errors++;
            $display("FAIL run6_state: busy/mode/stage=%b%b%b, required 110", busy, div_mode, div_stage);
        end
        reset = 1'b1;
        #1;
        checks++;
        if ({resp_valid, busy, req0_ready, req1_ready, div_mode, div_stage, resp_id} !== 7'b0000010 ||
            div_num !== '0 || div_den !== '0 || resp_quotient !== '0) begin
            errors++;
            $display("FAIL midrun_reset: ctrl=%b num=%h den=%h q=%h, required 0000010 and zeros",
                     {resp_valid, busy, req0_ready, req1_ready, div_mode, div_stage, resp_id},
                     div_num, div_den, resp_quotient);
        end
        sb.delete();
        @(negedge clk);
        reset = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (resp_valid !== 1'b0) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL ghost_resp: resp_valid seen after reset, required none");
        end
        req1_valid = 1'b1;
        req1_num = 30'h0100_0000;
        req1_den = 30'h2000_0000;
        #1;
        checks++;
        if (req0_ready !== 1'b0 || req1_ready !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_grant: r0=%b r1=%b, required 0 1", req0_ready, req1_ready);
        end
        sb.push_back('{id: 1'b1, q: STUB_Q, tol: 0});
        @(posedge clk);
        #1 req1_valid = 1'b0;
        wait_valid(cyc);
        take_resp();
    endtask

    task automatic test_real_divider();
        int cyc;
        use_real = 1'b1;
        @(negedge clk);
        req0_valid = 1'b1;
        req0_num = 30'h1000_0000;
        req0_den = 30'h1800_0000;
        sb.push_back('{id: 1'b0, q: 30'h1555_5555, tol: 512});
        @(posedge clk);
        #1 req0_valid = 1'b0;
        wait_valid(cyc);
        take_resp();
        use_real = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_backpressure();
        test_operand_stability();
        test_reset_mid_run();
        test_real_divider();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover: %0d responses never arrived, required 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/goldschmidt_sched.md
Name: goldschmidt_sched

Overview:
- Sequencer and two-port arbiter for the shared Goldschmidt divider datapath.
- Accepts divide requests from two requesters using valid/ready handshakes and picks between them round-robin.
- Holds the selected operands stable and drives the divider's mode/stage controls for 2+2*ITER cycles.
- Captures the quotient and returns it with the requester ID over a response handshake that supports backpressure.

Parameters:
- WIDTH, 30, operand and quotient width; must match the divider.
- ITER, 5, number of refinement iterations; each iteration is one n update plus one d/k update.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- req0_valid  in  1  requester 0 has an operation pending
- req0_ready  out  1  request 0 accepted this cycle
- req0_num  in  WIDTH  requester 0 numerator
- req0_den  in  WIDTH  requester 0 denominator
- req1_valid  in  1  requester 1 has an operation pending
- req1_ready  out  1  request 1 accepted this cycle
- req1_num  in  WIDTH  requester 1 numerator
- req1_den  in  WIDTH  requester 1 denominator
- div_mode  out  1  divider mode (0 = multiply by initial constant, 1 = multiply by k)
- div_stage  out  1  divider stage (0 = update n, 1 = update d/k)
- div_num  out  WIDTH  registered numerator to the divider
- div_den  out  WIDTH  registered denominator to the divider
- div_quotient  in  WIDTH  divider n-register output
- resp_valid  out  1  result available
- resp_ready  in  1  consumer accepts the result
- resp_id  out  1  requester that owns the result
- resp_quotient  out  WIDTH  captured quotient
- busy  out  1  high in RUN or DONE

Behaviour:
- States: IDLE, RUN, DONE.
- Reset (asynchronous): state=IDLE, cnt=0, last_grant=1, div_num=div_den=0, resp_quotient=0, resp_id=0, resp_valid=0, req*_ready=0.
- IDLE arbitration:
  - grant0 = req0_valid & (~req1_valid | last_grant==1).
  - grant1 = req1_valid & ~grant0.
  - reqN_ready = grantN, combinational, asserted only in IDLE.
  - Never both ready in the same cycle.
- On a handshake at clock edge E:
  - Latch the granted num/den into div_num/div_den.
  - resp_id = granted index; last_grant = granted index; cnt=0; go to RUN.
- RUN:
  - div_mode = (cnt>=2); div_stage = cnt[0].
  - cnt increments each cycle.
  - At cnt == 2*ITER+1: capture div_quotient into resp_quotient and go to DONE.
  - div_num/div_den stay stable for the whole operation.
- Control sequence for ITER=5: mode 0,0,1,1,...; stage 0,1,0,1,...; 12 RUN cycles.
- IDLE and DONE outputs: div_mode=0, div_stage=1. With stage=1 the divider's n register stays frozen.
- DONE:
  - resp_valid=1; resp_quotient/resp_id held stable until resp_valid & resp_ready.
  - After the handshake, return to IDLE.
  - A new request is accepted no earlier than the cycle after the response handshake.
- Latency: handshake in cycle t gives resp_valid first high in cycle t+3+2*ITER (cycle 13 for ITER=5).
- Backpressure: DONE holds indefinitely. Requests stay pending; ready stays 0 and requesters must hold valid and operands.
- Fairness: under continuous contention grants alternate 0,1,0,1. A lone requester is granted back-to-back.
- Reset mid-RUN or mid-DONE: immediately back to IDLE; the result is discarded and no response is issued.
- cnt width is clog2(2*ITER+2); it never wraps inside RUN.

Test Plan:
- Single request, divider stubbed: req0 num=0x1000_0000, den=0x2000_0000 at cycle 0.
  - req0_ready=1 in cycle 0.
  - div_mode/div_stage sequence 00,01,10,11,10,11,10,11,10,11,10,11.
  - Stub returns 0x0ABC_DEF0; resp_valid rises in cycle 13 with resp_id=0 and resp_quotient=0x0ABC_DEF0.
- Contention: both valid from reset.
  - Order of grants is 0,1,0,1; req1_ready is never high in the same cycle as req0_ready.
  - Each resp_id matches its grant.
- Backpressure: hold resp_ready=0 for 20 cycles after resp_valid.
  - resp_quotient stays stable; req*_ready stay 0.
  - busy=1; div_stage=1 for the whole stall.
- Operand stability: change req0_num/req0_den after the handshake.
  - div_num/div_den keep the latched values through RUN and DONE.
- Reset asserted at RUN cycle 6: all outputs go to reset values immediately and no resp_valid follows.
  - A later req1 is granted first, since reset sets last_grant=1 and only req1 is valid.
- Real divider with ITER=5: num=0.5, den=0.75 (Q1.29).
  - resp_quotient is within 2^-20 of 0.6667 (0x1555_5555).
